uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL take parameter CLOCK_FREQ, default 50_000_000, meaning the Clock frequency in Hz.
REQ-002 The block SHALL take parameter BAUD_RATE, default 115_200, meaning the serial bit rate in bits/s.
REQ-003 The block SHALL take parameter FIFO_DEPTH, default 4, meaning the number of byte entries in the transmit queue; it is a power of two and at least 2.
REQ-004 Port Clock  input  1  sole clock; all state updates on rising edge.
REQ-005 Port Reset  input  1  reset; asynchronous and active-high.
REQ-006 Port DataIn  input  8  byte to transmit.
REQ-007 Port DataInValid  input  1  DataIn holds a byte offered for transmission.
REQ-008 Port DataInReady  output  1  the queue can accept a byte this cycle.
REQ-009 Port SOut  output  1  serial line; idles high.
REQ-010 Port Busy  output  1  the queue is non-empty or a frame is in flight.

Function
REQ-011 The block SHALL define bit period BIT_CYCLES = CLOCK_FREQ / BAUD_RATE with integer truncation.
- Every serial symbol SHALL last exactly BIT_CYCLES cycles, timed by a down-counter reloaded at each symbol start.
REQ-012 DataInReady SHALL equal "queue not full" and SHALL depend only on registered state, never on DataInValid.
REQ-013 A byte SHALL be pushed on a rising edge where DataInValid and DataInReady are both 1.
- While the queue is full, a push SHALL NOT be accepted even if a pop occurs in the same cycle.
REQ-014 A simultaneous push and pop on a non-full, non-empty queue SHALL leave the occupancy unchanged.
- The queue SHALL preserve FIFO order.
- Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-015 The state machine SHALL use states IDLE, START, DATA and STOP, plus PARITY when the macro in REQ-026 is defined.
REQ-016 In IDLE with a non-empty queue, the block SHALL pop the head byte into the shift register and enter START on the same edge.
- SOut SHALL go low on the cycle following that edge.
REQ-017 START SHALL drive SOut=0 for one bit period, then enter DATA.
REQ-018 DATA SHALL drive the 8 data bits LSB first, one bit period each, tracked by a 3-bit index counter.
- After bit 7 the block SHALL enter STOP, or PARITY when enabled.
REQ-019 STOP SHALL drive SOut=1 for one bit period. At the end of STOP:
- if the queue is non-empty, the block SHALL pop and enter START directly, with no idle gap between frames;
- otherwise it SHALL enter IDLE.
REQ-020 SOut SHALL be registered, glitch-free, and 1 in IDLE.
REQ-021 Busy SHALL be 1 whenever the state is not IDLE or the queue is non-empty.
REQ-022 DataIn SHALL be sampled only on an accepted push.
- Changes to DataIn during a frame SHALL NOT affect bytes already queued or in flight.

Reset
REQ-023 Asserting Reset SHALL immediately force the following, independent of Clock:
- SOut=1, Busy=0, state IDLE;
- queue empty, so DataInReady=1;
- bit counter, index counter and pointers cleared.
REQ-024 Reset asserted mid-frame SHALL abort the frame; no partial frame SHALL resume after release.
REQ-025 After Reset deasserts, the first push SHALL be accepted on the next rising edge.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined, the block SHALL insert a PARITY state after DATA that drives the even-parity bit (XOR of the 8 data bits) for one bit period before STOP, giving an 11-bit frame.
- Without the macro, the PARITY state and its logic SHALL be absent and the frame SHALL be 10 bits.

Verification
REQ-027 CLOCK_FREQ=1000, BAUD_RATE=100, push 0x55 -> SOut low for 10 cycles, then 1,0,1,0,1,0,1,0 for 10 cycles each, then high for 10 cycles; Busy falls after the stop bit.
REQ-028 Push 0x01, 0x80, 0xFF back-to-back -> three frames with the START of each directly following the previous STOP; bytes arrive in order.
REQ-029 FIFO_DEPTH=4, push 6 bytes with DataInValid held high -> DataInReady drops after 5 accepted pushes (1 in flight plus 4 queued); the 6th byte is accepted once the first queued byte is popped.
REQ-030 Assert Reset during data bit 3 of 0xA5 -> SOut=1 immediately, Busy=0, DataInReady=1; no further transitions appear after release until a new push.
REQ-031 With UART_TX_PARITY_EN defined, push 0x07 -> parity bit 1 precedes the stop bit.
- Push 0x03 -> parity bit 0.
- Total frame length is 110 cycles.
REQ-032 DataInValid=1 while DataInReady=0 for 20 cycles -> no push; queue contents and occupancy unchanged.

Source files
------------

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// Purpose
//   Byte-oriented UART transmitter with a small transmit queue. Bytes are
//   accepted through a valid/ready handshake, held in a FIFO, and serialised
//   as 8N1 frames (start bit, 8 data bits LSB first, stop bit). Frames are
//   sent back-to-back with no idle gap while the queue has data.
//
// Parameters
//   CLOCK_FREQ  clock frequency in Hz
//   BAUD_RATE   serial bit rate in bits/s; one bit lasts
//               BIT_CYCLES = CLOCK_FREQ / BAUD_RATE clocks (truncated)
//   FIFO_DEPTH  transmit queue entries; power of two, >= 2
//
// Ports
//   Clock        in   sole clock, rising edge
//   Reset        in   asynchronous, active-high reset
//   DataIn       in   [7:0] byte offered for transmission
//   DataInValid  in   DataIn holds a byte
//   DataInReady  out  queue not full (registered state only)
//   SOut         out  registered serial line, idles high
//   Busy         out  queue non-empty or a frame in flight
//   DebugState   out  [2:0] current FSM state encoding, for observation only
//
// Handshake
//   A byte is taken on a rising edge where DataInValid && DataInReady.
//   DataInReady never looks at DataInValid, so a producer may hold
//   DataInValid high indefinitely; while the queue is full nothing is taken,
//   even on a cycle where the transmitter pops the head entry.
//
// Build option
//   UART_TX_PARITY_EN  when defined, a PARITY state after DATA sends the
//                      even-parity bit (XOR of the data bits), giving an
//                      11-bit frame. Undefined: plain 10-bit frame.
// -----------------------------------------------------------------------------
module uart_transmitter #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic       SOut,
  output logic       Busy,
  output logic [2:0] DebugState
);

  localparam int BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   OCC_ONE    = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   OCC_FULL   = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_e;

  // ---------------------------------------------------------------------------
  // Transmit queue
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   occ_q;
  logic             fifo_empty;
  logic [7:0]       fifo_head;
  logic             push;
  logic             pop;

  assign fifo_empty  = (occ_q == '0);
  assign fifo_head   = mem_q[rd_ptr_q];
  assign DataInReady = (occ_q != OCC_FULL);
  assign push        = DataInValid && DataInReady;

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_ONE;
        2'b01:   occ_q <= occ_q - OCC_ONE;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written,
  // and reset empties the queue through the pointers and occupancy.
  always_ff @(posedge Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= DataIn;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  state_e           state_q,   state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       idx_q,     idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic             sout_q,    sout_d;
  logic             bit_done;
  logic             load_frame;
`ifdef UART_TX_PARITY_EN
  logic             parity_q,  parity_d;
`endif

  // The down-counter reaches zero on the last cycle of the current symbol.
  assign bit_done = (bit_cnt_q == '0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      sout_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      sout_q    <= sout_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // sout_d is the level of the symbol that starts on the next edge, so the
  // line comes straight from a flop and never glitches.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    sout_d     = sout_q;
    load_frame = 1'b0;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if ((state_q != IDLE) && !bit_done) begin
      bit_cnt_d = bit_cnt_q - CNT_ONE;
    end

    case (state_q)
      IDLE: begin
        sout_d = 1'b1;
        if (!fifo_empty) begin
          load_frame = 1'b1;
        end
      end

      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_cnt_d = CNT_RELOAD;
          idx_d     = 3'd0;
          sout_d    = shift_q[0];
        end
      end

      DATA: begin
        if (bit_done) begin
          bit_cnt_d = CNT_RELOAD;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            sout_d  = parity_q;
`else
            state_d = STOP;
            sout_d  = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            sout_d  = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d   = STOP;
          bit_cnt_d = CNT_RELOAD;
          sout_d    = 1'b1;
        end
      end
`endif

      STOP: begin
        if (bit_done) begin
          // Chain straight into the next frame when data is waiting.
          if (!fifo_empty) begin
            load_frame = 1'b1;
          end else begin
            state_d = IDLE;
            sout_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        sout_d    = 1'b1;
      end
    endcase

    // Shared frame launch from IDLE and from the end of STOP: pop the head
    // byte and drive the start bit from the next edge.
    if (load_frame) begin
      pop       = 1'b1;
      shift_d   = fifo_head;
      state_d   = START;
      bit_cnt_d = CNT_RELOAD;
      idx_d     = 3'd0;
      sout_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = ^fifo_head;
`endif
    end
  end

  assign SOut       = sout_q;
  assign Busy       = (state_q != IDLE) || !fifo_empty;
  assign DebugState = state_q;

endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 4;
  localparam int BIT_CYC  = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NSYM = 11;
`else
  localparam int NSYM = 10;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sout;
  logic       busy;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  uart_transmitter #(
    .CLOCK_FREQ(CLK_FREQ),
    .BAUD_RATE (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .Clock      (clk),
    .Reset      (rst),
    .DataIn     (din),
    .DataInValid(din_valid),
    .DataInReady(din_ready),
    .SOut       (sout),
    .Busy       (busy),
    .DebugState (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] feed[8];
  logic       last_par_bit;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all enter and leave on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic push_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    din       = b;
    din_valid = 1'b1;
    for (int w = 0; w < 300; w++) begin
      if (din_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL push_ready: ready=%b, required 1 within 300 cycles", din_ready);
    end else begin
      exp_q.push_back(b);
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Holds valid high and offers feed[0..n-1] in order as ready allows.
  task automatic feed_burst(input int n, output int accepted,
                            output int first_low, output int low_cnt);
    bit acc;
    accepted  = 0;
    first_low = -1;
    low_cnt   = 0;
    din_valid = 1'b1;
    din       = feed[0];
    for (int c = 0; c < 300 && accepted < n; c++) begin
      acc = (din_ready === 1'b1);
      if (!acc) begin
        low_cnt++;
        if (first_low < 0) first_low = accepted;
      end else begin
        exp_q.push_back(din);
      end
      @(negedge clk);
      if (acc) begin
        accepted++;
        if (accepted < n) din = feed[accepted];
      end
    end
  endtask

  // Receiver model: finds the start bit within budget cycles, then checks
  // every cycle of every symbol against the next expected byte.
  task automatic check_frame(input int budget, input string tag);
    bit         ok;
    logic [7:0] b;
    logic       exp_bit;
    logic       got;
    int         errs;
    ok = 0;
    for (int w = 0; w <= budget; w++) begin
      if (sout === 1'b0) begin ok = 1; break; end
      @(negedge clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s start: sout=%b, required 0 within %0d cycles", tag, sout, budget);
      return;
    end
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s extra_frame: frame seen, required none queued", tag);
      return;
    end
    b = exp_q.pop_front();
    for (int s = 0; s < NSYM; s++) begin
      exp_bit = 1'b1;
      if (s == 0) exp_bit = 1'b0;
      else if (s <= 8) exp_bit = b[s-1];
`ifdef UART_TX_PARITY_EN
      else if (s == 9) exp_bit = ^b;
`endif
      errs = 0;
      got  = exp_bit;
      for (int c = 0; c < BIT_CYC; c++) begin
        if (sout !== exp_bit) begin errs++; got = sout; end
        if (s == 9 && c == 5) last_par_bit = sout;
        @(negedge clk);
      end
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL %s byte=%02h sym%0d: got %b, required %b (%0d bad cycles)",
                 tag, b, s, got, exp_bit, errs);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst = 1'b1; din = 8'h00; din_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (sout !== 1'b1) begin bad++; $display("FAIL reset_sout: got %b, required 1", sout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b, required 1", din_ready); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
  endtask

  task automatic test_single;
    push_byte(8'h55);
    // Byte is queued but not yet popped: line still idle, Busy already up.
    total++; if (sout !== 1'b1) begin bad++; $display("FAIL single_latency: sout=%b, required 1", sout); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b, required 1", busy); end
    @(negedge clk);
    check_frame(0, "single55");
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b, required 0", busy); end
  endtask

  task automatic test_back_to_back;
    fork
      begin
        push_byte(8'h01);
        push_byte(8'h80);
        push_byte(8'hFF);
        // Input bus churn must not reach queued or in-flight bytes.
        repeat (60) begin
          @(negedge clk);
          din = 8'($urandom_range(0, 255));
        end
      end
      begin
        check_frame(4, "b2b_0");
        check_frame(0, "b2b_1");
        check_frame(0, "b2b_2");
      end
    join
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end: got %b, required 0", busy); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_leftover: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_full;
    int accepted, first_low, low_cnt;
    feed[0] = 8'h11; feed[1] = 8'h22; feed[2] = 8'h33;
    feed[3] = 8'h44; feed[4] = 8'h66; feed[5] = 8'h99;
    fork
      begin
        feed_burst(6, accepted, first_low, low_cnt);
        din_valid = 1'b0;
      end
      begin
        check_frame(4, "full_0");
        for (int k = 1; k < 6; k++) check_frame(0, $sformatf("full_%0d", k));
      end
    join
    total++; if (first_low != 5) begin bad++; $display("FAIL full_drop_point: got %0d, required 5", first_low); end
    // Ready low from 4 cycles after the first push until the end of frame 1.
    total++; if (low_cnt != 97) begin bad++; $display("FAIL full_low_cycles: got %0d, required 97", low_cnt); end
    total++; if (accepted != 6) begin bad++; $display("FAIL full_accepted: got %0d, required 6", accepted); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_end: got %b, required 0", busy); end
  endtask

  task automatic test_hold_off;
    int accepted, first_low, low_cnt, ready_hi, idle_bad;
    feed[0] = 8'h5A; feed[1] = 8'hC3; feed[2] = 8'h0F; feed[3] = 8'hF0; feed[4] = 8'h81;
    ready_hi = 0;
    idle_bad = 0;
    fork
      begin
        feed_burst(5, accepted, first_low, low_cnt);
        din = 8'hEE;
        for (int c = 0; c < 20; c++) begin
          if (din_ready !== 1'b0) ready_hi++;
          @(negedge clk);
        end
        din_valid = 1'b0;
      end
      begin
        check_frame(4, "hold_0");
        for (int k = 1; k < 5; k++) check_frame(0, $sformatf("hold_%0d", k));
        for (int c = 0; c < 30; c++) begin
          if (sout !== 1'b1 || busy !== 1'b0) idle_bad++;
          @(negedge clk);
        end
      end
    join
    total++; if (accepted != 5) begin bad++; $display("FAIL hold_accepted: got %0d, required 5", accepted); end
    total++; if (ready_hi != 0) begin bad++; $display("FAIL hold_ready: got %0d high cycles, required 0", ready_hi); end
    total++; if (idle_bad != 0) begin bad++; $display("FAIL hold_extra: got %0d active cycles, required 0", idle_bad); end
  endtask

  task automatic test_reset_midframe;
    bit ok;
    int quiet_bad;
    push_byte(8'hA5);
    ok = 0;
    for (int w = 0; w < 5; w++) begin
      if (sout === 1'b0) begin ok = 1; break; end
      @(negedge clk);
    end
    total++; if (!ok) begin bad++; $display("FAIL midrst_start: sout=%b, required 0", sout); end
    repeat (45) @(negedge clk);
    // Middle of data bit 3 of 0xA5, which is 0.
    total++; if (sout !== 1'b0) begin bad++; $display("FAIL midrst_bit3: got %b, required 0", sout); end
    #1 rst = 1'b1;
    #1;
    total++; if (sout !== 1'b1) begin bad++; $display("FAIL midrst_sout: got %b, required 1", sout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b, required 1", din_ready); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL midrst_state: got %0d, required 0", dbg_state); end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    quiet_bad = 0;
    for (int c = 0; c < 150; c++) begin
      if (sout !== 1'b1 || busy !== 1'b0) quiet_bad++;
      @(negedge clk);
    end
    total++; if (quiet_bad != 0) begin bad++; $display("FAIL midrst_quiet: got %0d active cycles, required 0", quiet_bad); end

    // Push offered on the same falling edge that releases reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; din = 8'h3C; din_valid = 1'b1;
    exp_q.push_back(8'h3C);
    @(negedge clk);
    din_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_first_push: busy=%b, required 1", busy); end
    check_frame(2, "post_rst");
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy: got %b, required 0", busy); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    int len;
    logic par;
    bit ok;
    push_byte(8'h07);
    check_frame(4, "par07");
    total++; if (last_par_bit !== 1'b1) begin bad++; $display("FAIL parity_07: got %b, required 1", last_par_bit); end
    push_byte(8'h03);
    void'(exp_q.pop_back());
    ok = 0;
    for (int w = 0; w < 5; w++) begin
      if (sout === 1'b0) begin ok = 1; break; end
      @(negedge clk);
    end
    len = 0;
    par = 1'bx;
    while (ok && busy === 1'b1 && len < 200) begin
      if (len == 95) par = sout;
      len++;
      @(negedge clk);
    end
    total++; if (par !== 1'b0) begin bad++; $display("FAIL parity_03: got %b, required 0", par); end
    total++; if (len != 110) begin bad++; $display("FAIL parity_len: got %0d, required 110", len); end
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_hold_off();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
